// File: rtl/bert_pkg.sv
// Shared definitions for the BERT pattern generator and checker:
// PRBS7 taps, default seed, FSM state encoding and injection counter width.
package bert_pkg;

    // PRBS7 polynomial x^7 + x^6 + 1: feedback from state bits 6 and 5
    localparam int unsigned PRBS7_TAP_A = 6;
    localparam int unsigned PRBS7_TAP_B = 5;

    // Replaces an all-zero seed, which would lock the LFSR at zero
    localparam logic [6:0] PRBS7_SEED_DEFAULT = 7'h7F;

    localparam int unsigned INJ_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_t;

    // Number of set bits in an 8-bit mask
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs7_step8.sv
// Combinational PRBS7 stepper: advances the LFSR eight steps and returns
// the produced bits as one word, earliest bit in the MSB.
module prbs7_step8
    import bert_pkg::*;
(
    input  logic [6:0] i_state,
    output logic [6:0] o_state,
    output logic [7:0] o_word
);

    logic [6:0] w_s;
    logic       w_b;

    // Eight unrolled LFSR steps; each feedback bit is shifted into the word
    always_comb begin
        w_s    = i_state;
        w_b    = 1'b0;
        o_word = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_b    = w_s[PRBS7_TAP_A] ^ w_s[PRBS7_TAP_B];
            w_s    = {w_s[5:0], w_b};
            o_word = {o_word[6:0], w_b};
        end
        o_state = w_s;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// PRBS7 byte-stream source with valid/ready output for the BERT link.
// Optional error injection is built only when PRBS_GEN_ERR_INJ_EN is defined;
// otherwise inj_req/inj_mask are ignored and out_inj/inj_count read zero.
module prbs_pattern_gen
    import bert_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BURST_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [6:0]           seed,
    input  logic [BURST_W-1:0]   burst_len,
    input  logic                 inj_req,
    input  logic [DATA_W-1:0]    inj_mask,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inj,
    output logic                 busy,
    output logic                 done,
    output logic [BURST_W-1:0]   word_count,
    output logic [INJ_CNT_W-1:0] inj_count
);

    gen_state_t         r_state;
    gen_state_t         w_state_next;
    logic [6:0]         r_lfsr;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_stop;
    logic [BURST_W-1:0] r_word_cnt;

    logic [6:0]         w_seed_eff;
    logic [6:0]         w_step_in;
    logic [6:0]         w_step_out;
    logic [7:0]         w_word;
    logic [DATA_W-1:0]  w_word_out;
    logic [BURST_W-1:0] w_cnt_inc;
    logic               w_acc;
    logic               w_last;
    logic               w_stop_seen;
    logic               w_load;
    logic               w_finish;

    assign w_seed_eff  = (seed == '0) ? PRBS7_SEED_DEFAULT : seed;
    // r_lfsr holds the state following the presented word, so the next word
    // is always ready combinationally; SEED bypasses it with the fresh seed.
    assign w_step_in   = (r_state == ST_SEED) ? w_seed_eff : r_lfsr;
    assign w_acc       = r_valid & out_ready;
    assign w_cnt_inc   = r_word_cnt + BURST_W'(1);
    assign w_last      = (burst_len != '0) && (w_cnt_inc == burst_len);
    assign w_stop_seen = r_stop | stop;

    prbs7_step8 u_step (
        .i_state (w_step_in),
        .o_state (w_step_out),
        .o_word  (w_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state plus word-load / stream-finish strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_SEED;
            ST_SEED: begin
                w_load       = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_acc) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                        w_finish     = 1'b1;
                    end else if (w_stop_seen) begin
                        w_state_next = ST_IDLE;
                        w_finish     = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end else if (w_stop_seen && !r_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: LFSR advance, output word, valid flag, word counter, stop latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= PRBS7_SEED_DEFAULT;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_word_cnt <= '0;
            r_stop     <= 1'b0;
        end else begin
            if (w_load) begin
                r_lfsr  <= w_step_out;
                r_data  <= w_word_out;
                r_valid <= 1'b1;
            end else if (w_finish) begin
                r_valid <= 1'b0;
            end

            if (r_state == ST_SEED) r_word_cnt <= '0;
            else if (w_acc)         r_word_cnt <= w_cnt_inc;

            if ((r_state == ST_SEED || r_state == ST_RUN) && w_state_next != ST_IDLE
                && w_state_next != ST_DONE)
                r_stop <= w_stop_seen;
            else
                r_stop <= 1'b0;
        end
    end

`ifdef PRBS_GEN_ERR_INJ_EN
    logic [DATA_W-1:0]    r_inj_pend;
    logic [DATA_W-1:0]    r_cur_mask;
    logic [INJ_CNT_W-1:0] r_inj_cnt;
    logic [DATA_W-1:0]    w_mask_eff;
    logic [INJ_CNT_W:0]   w_inj_sum;
    logic                 w_inj_window;

    assign w_inj_window = (r_state == ST_SEED) || (r_state == ST_RUN);
    // A request arriving in the same cycle as a load still reaches that word
    assign w_mask_eff   = r_inj_pend | ((inj_req && w_inj_window) ? inj_mask : '0);
    assign w_inj_sum    = {1'b0, r_inj_cnt} + (INJ_CNT_W + 1)'(popcount8(r_cur_mask));
    assign w_word_out   = w_word ^ w_mask_eff;
    assign out_inj      = |r_cur_mask;
    assign inj_count    = r_inj_cnt;

    // Pending mask collects requests until the next fresh word; count flips on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inj_pend <= '0;
            r_cur_mask <= '0;
            r_inj_cnt  <= '0;
        end else begin
            if (!w_inj_window || w_load) r_inj_pend <= '0;
            else                         r_inj_pend <= w_mask_eff;

            if (w_load)        r_cur_mask <= w_mask_eff;
            else if (w_finish) r_cur_mask <= '0;

            if (r_state == ST_SEED)
                r_inj_cnt <= '0;
            else if (w_acc && r_cur_mask != '0)
                r_inj_cnt <= w_inj_sum[INJ_CNT_W] ? '1 : w_inj_sum[INJ_CNT_W-1:0];
        end
    end
`else
    logic w_unused_inj;

    assign w_unused_inj = ^{inj_req, inj_mask};
    assign w_word_out   = w_word;
    assign out_inj      = 1'b0;
    assign inj_count    = '0;
`endif

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign word_count = r_word_cnt;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Directed test for prbs_pattern_gen: PRBS7 words, handshake stalls,
// burst completion, stop draining, error injection and async reset.
module tb_prbs_pattern_gen;

`ifdef PRBS_GEN_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [6:0]  seed;
    logic [15:0] burst_len;
    logic        inj_req;
    logic [7:0]  inj_mask;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_inj;
    logic        busy;
    logic        done;
    logic [15:0] word_count;
    logic [15:0] inj_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [6:0]  m_state;
    logic [7:0]  m_word;

    always #5 clk = ~clk;

    prbs_pattern_gen #(.DATA_W(8), .BURST_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .seed       (seed),
        .burst_len  (burst_len),
        .inj_req    (inj_req),
        .inj_mask   (inj_mask),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inj    (out_inj),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .inj_count  (inj_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference PRBS7 word generator: advances m_state by eight steps
    task automatic model_word();
        logic fb;
        m_word = '0;
        for (int k = 0; k < 8; k++) begin
            fb      = m_state[6] ^ m_state[5];
            m_state = {m_state[5:0], fb};
            m_word  = {m_word[6:0], fb};
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = '0; burst_len = '0;
        inj_req = 1'b0; inj_mask = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_data",  out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_inj",   out_inj, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_wc",    word_count, 0);
        check("rst_ic",    inj_count, 0);
        rst_n = 1'b1;
        tick();

        // T1: seed 0 -> default seed, burst of 3 with sink always ready
        seed = 7'h00; burst_len = 16'd3; out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("t1_seed_busy",  busy, 1);
        check("t1_seed_valid", out_valid, 0);
        tick();
        check("t1_w1_valid", out_valid, 1);
        check("t1_w1_data",  out_data, 8'h02);
        tick();
        check("t1_w2_data",  out_data, 8'h0C);
        check("t1_w2_wc",    word_count, 1);
        tick();
        check("t1_w3_data",  out_data, 8'h28);
        check("t1_w3_wc",    word_count, 2);
        tick();
        check("t1_end_valid", out_valid, 0);
        check("t1_end_done",  done, 1);
        check("t1_end_busy",  busy, 1);
        check("t1_end_wc",    word_count, 3);
        tick();
        check("t1_idle_done", done, 0);
        check("t1_idle_busy", busy, 0);

        // T2: 5-cycle stall on first word, injection 0x81 requested during the stall
        seed = 7'h7F; burst_len = 16'd2; out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t2_w1_valid", out_valid, 1);
        check("t2_w1_data",  out_data, 8'h02);
        inj_req = 1'b1; inj_mask = 8'h81;
        for (int i = 0; i < 5; i++) begin
            tick();
            inj_req = 1'b0;
            check("t2_stall_valid", out_valid, 1);
            check("t2_stall_data",  out_data, 8'h02);
            check("t2_stall_inj",   out_inj, 0);
        end
        out_ready = 1'b1;
        tick();
        check("t2_w2_valid", out_valid, 1);
        check("t2_w2_data",  out_data, INJ ? 8'h8D : 8'h0C);
        check("t2_w2_inj",   out_inj, INJ ? 1 : 0);
        check("t2_w2_wc",    word_count, 1);
        tick();
        check("t2_end_done", done, 1);
        check("t2_end_ic",   inj_count, INJ ? 2 : 0);
        check("t2_end_wc",   word_count, 2);
        tick();

        // T3: two requests (0x01, 0x10) merge into one injected word
        seed = 7'h00; burst_len = 16'd3; out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t3_w1_data", out_data, 8'h02);
        check("t3_ic_clr",  inj_count, 0);
        inj_req = 1'b1; inj_mask = 8'h01; tick();
        inj_mask = 8'h10; tick();
        inj_req = 1'b0; inj_mask = 8'h00;
        check("t3_stall_data", out_data, 8'h02);
        out_ready = 1'b1;
        tick();
        check("t3_w2_data", out_data, INJ ? 8'h1D : 8'h0C);
        check("t3_w2_inj",  out_inj, INJ ? 1 : 0);
        tick();
        check("t3_w3_data", out_data, 8'h28);
        check("t3_w3_inj",  out_inj, 0);
        tick();
        check("t3_end_done", done, 1);
        check("t3_end_ic",   inj_count, INJ ? 2 : 0);
        tick();

        // T4: continuous mode, stop while the 11th word is stalled
        seed = 7'h00; burst_len = 16'd0; out_ready = 1'b1;
        m_state = 7'h7F;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            model_word();
            check("t4_stream_data", out_data, m_word);
            tick();
        end
        out_ready = 1'b0;
        check("t4_wc10", word_count, 10);
        model_word();
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_data",  out_data, m_word);
        check("t4_hold_busy",  busy, 1);
        tick();
        check("t4_hold2_valid", out_valid, 1);
        check("t4_hold2_done",  done, 0);
        out_ready = 1'b1;
        tick();
        check("t4_end_valid", out_valid, 0);
        check("t4_end_busy",  busy, 0);
        check("t4_end_done",  done, 0);
        check("t4_end_wc",    word_count, 11);
        tick();
        check("t4_after_done", done, 0);

        // T5: asynchronous reset mid-burst, then a fresh start replays 0x02
        seed = 7'h00; burst_len = 16'd0; out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        inj_req = 1'b1; inj_mask = 8'hFF;
        tick();
        inj_req = 1'b0; inj_mask = 8'h00;
        tick();
        check("t5_pre_data", out_data, 8'h28);
        check("t5_pre_ic",   inj_count, INJ ? 8 : 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_data",  out_data, 0);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_inj",   out_inj, 0);
        check("t5_rst_busy",  busy, 0);
        check("t5_rst_wc",    word_count, 0);
        check("t5_rst_ic",    inj_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t5_replay_valid", out_valid, 1);
        check("t5_replay_data",  out_data, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_pattern_gen.md
# prbs_pattern_gen

Transmit-side pattern source for the bit-error-ratio tester. It produces a PRBS7 (x^7 + x^6 + 1) byte stream over a valid/ready handshake and feeds the link whose far end is the comparator/error checker. Optionally it XORs a host-supplied error mask into selected words, so the checker's error total can be validated against a known injected count.

## Interface
- `DATA_W`, 8: word width. Only 8 is supported.
- `BURST_W`, 16: width of the burst-length and word counters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; accepted only in IDLE
- `stop`  in  1  pulse; ends RUN after the current handshake completes
- `seed`  in  7  LFSR seed, sampled in SEED; 0 is replaced by 7'h7F
- `burst_len`  in  BURST_W  number of words to send; 0 = continuous
- `inj_req`  in  1  pulse; arms error injection with `inj_mask`
- `inj_mask`  in  DATA_W  bits to invert in the injected word
- `out_data`  out  DATA_W  pattern word; MSB is the earliest bit
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  sink accepts the word
- `out_inj`  out  1  the current word carries an injected mask
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse when a burst completes
- `word_count`  out  BURST_W  words accepted since `start`
- `inj_count`  out  16  total injected bit flips accepted; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, SEED, RUN, DONE.
- IDLE -> SEED on `start`.
- SEED: load the LFSR from `seed`, clear `word_count` and `inj_count`, build the first word. Then go to RUN.
- RUN -> DONE when the accepted word makes `word_count == burst_len` (`burst_len != 0`).
- RUN -> IDLE when `stop` was seen and no unaccepted word is pending.
- DONE -> IDLE after one cycle.
- LFSR step: b = s[6] ^ s[5]; s <= {s[5:0], b}; the output bit is b.
- Each word is 8 steps, computed combinationally. The first bit goes to `out_data[7]`.
- The LFSR advances only when a word is accepted (`out_valid && out_ready`).
- Handshake:
  - `out_data` and `out_inj` stay stable while `out_valid && !out_ready`.
  - `out_valid` stays high until the word is accepted.
  - In RUN with a next word, `out_valid` is high continuously: back-to-back acceptance gives one word per cycle.
- `stop` is latched. A pending word is still delivered, then the block returns to IDLE without raising `done`.
- `start` outside IDLE is ignored.
- An `inj_req` in IDLE or DONE is dropped.
- `word_count` increments on every accepted word and wraps modulo 2^BURST_W in continuous mode.

## Timing
- Reset values:
  - state IDLE, LFSR 7'h7F
  - `out_data` 0, `out_valid` 0, `out_inj` 0
  - `busy` 0, `done` 0
  - `word_count` 0, `inj_count` 0
- Reset mid-burst clears everything immediately, with no drain.
- `start` at cycle N: SEED at N+1, first `out_valid` at N+2.
- After acceptance at cycle K, the next word is valid at K+1.
- Last burst word accepted at cycle K: `out_valid` low and `done` high at K+1, `busy` low at K+2.
- Injection:
  - `inj_req` arms a pending mask. The mask applies to the next freshly presented word, never to a word already valid and stalled.
  - A second `inj_req` while a mask is pending ORs into the pending mask.
  - An all-zero mask sets neither `out_inj` nor the count.
- `inj_count += popcount(mask)` when the injected word is accepted.

## Configuration
- Macro `PRBS_GEN_ERR_INJ_EN`.
- Defined: injection logic is present, as described above.
- Undefined: `inj_req` and `inj_mask` are ignored; `out_inj` and `inj_count` are tied to 0; `out_data` is the pure PRBS sequence.

## Structure
- Shared package `bert_pkg` holds:
  - PRBS7 tap positions (6, 5)
  - default seed 7'h7F
  - the FSM state enum
  - `INJ_CNT_W` = 16
- Sub-module `prbs7_step8`: combinational. Takes the current state, returns the next state and the 8-bit word. It is reused by the checker side.

## Test plan
- Seed 0, `burst_len` 3, `out_ready` high: words 0x02, 0x0C, then the next word; `done` pulses one cycle after the third acceptance; `word_count` = 3.
- `out_ready` low for 5 cycles after the first valid: 0x02 holds stable with `out_valid` high; 0x0C follows one cycle after acceptance.
- `inj_req` with mask 0x81 during a stalled word: that word is unchanged; the next word is XOR 0x81 with `out_inj` = 1; `inj_count` = 2.
- Two `inj_req`s (0x01, 0x10) before a word boundary: one word XOR 0x11; `inj_count` = 2.
- `burst_len` 0, `stop` after 10 accepted words while a word is stalled: that word is delivered, then IDLE, with no `done`.
- `rst_n` low mid-burst: all outputs return to reset values asynchronously; a fresh `start` replays 0x02 first.
